// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like port to AXI read bridge: one-entry AR holding register, bounded outstanding count, registered R return.
// Optional macro INST_BRIDGE_PERF_EN adds request/stall performance counters.
module inst_axi_rd_bridge #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  inst_rid,
    output logic        inst_bus_err,
    output logic        proto_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
`ifdef INST_BRIDGE_PERF_EN
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        rready
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, AR_BUSY} state_t;

    state_t        state_q;
    logic          arvalid_q;
    logic [31:0]   araddr_q;
    logic [2:0]    arsize_q;
    logic [CW-1:0] out_q, out_d;
    logic          addr_ok;
    logic          beat;
    logic          dec;
    logic          data_ok_q;
    logic [31:0]   rdata_q;
    logic [3:0]    rid_q;
    logic          bus_err_q;
    logic          proto_err_q;
    logic          unused_inputs;

    // Write-side fetch signals and rlast carry no information for a single-beat read bridge.
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rlast};

    assign beat    = rvalid;
    assign dec     = beat && (out_q != '0);
    assign addr_ok = (state_q == IDLE) && inst_sram_req && (out_q < MAX_C);

    always_comb begin
        out_d = out_q;
        if (addr_ok && !dec)
            out_d = out_q + 1'b1;
        else if (!addr_ok && dec)
            out_d = out_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arsize_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (addr_ok) begin
                        araddr_q  <= inst_sram_addr;
                        arsize_q  <= {1'b0, inst_sram_size};
                        arvalid_q <= 1'b1;
                        state_q   <= AR_BUSY;
                    end
                end
                AR_BUSY: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // A beat with nothing outstanding is still forwarded; it only flags the protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            data_ok_q   <= 1'b0;
            rdata_q     <= '0;
            rid_q       <= '0;
            bus_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            data_ok_q <= beat;
            if (beat) begin
                rdata_q   <= rdata;
                rid_q     <= rid;
                bus_err_q <= (rresp != 2'b00);
                if (out_q == '0)
                    proto_err_q <= 1'b1;
            end
        end
    end

`ifdef INST_BRIDGE_PERF_EN
    logic [31:0] perf_req_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (addr_ok)
                perf_req_q <= perf_req_q + 32'd1;
            if (inst_sram_req && !addr_ok)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_req_cnt   = perf_req_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
    assign inst_rid          = rid_q;
    assign inst_bus_err      = bus_err_q;
    assign proto_err         = proto_err_q;
    assign arid              = ARID_VAL;
    assign araddr            = araddr_q;
    assign arlen             = 8'd0;
    assign arsize            = arsize_q;
    assign arburst           = 2'b01;
    assign arlock            = 2'b00;
    assign arcache           = 4'b0000;
    assign arprot            = 3'b000;
    assign arvalid           = arvalid_q;
    assign rready            = 1'b1;

endmodule
